mux_out_port: RTL and testbench

Output-port stage directly downstream of the 7-input priority/reduction mux. It accepts the mux's registered `out` word stream and buffers it in a small FIFO. It forwards words onto the inter-node link under credit-based flow control and raises a stall back to the mux early enough to absorb the mux's 3-stage pipeline.

---
 rtl/mux_out_port.sv | 107 ++++++++++
 tb/tb_mux_out_port.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_out_port.sv
// Output port behind the 7-input mux: FIFO buffer, credit-based link sender, early stall.
// Optional head-of-line priority aging is enabled by defining MUX_OUT_PORT_AGING_EN.
module mux_out_port #(
  parameter int DataWidth    = 256,
  parameter int PriorityPos  = 152,
  parameter int BufferDepth  = 8,
  parameter int SkidSlots    = 3,
  parameter int CreditInit   = 4,
  parameter int AgeThreshold = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DataWidth-1:0]          in_data,
  input  logic                          credit_return,
  output logic [DataWidth-1:0]          out_data,
  output logic                          out_stall,
  output logic [$clog2(CreditInit+1)-1:0] credit_count,
  output logic                          overflow_err,
  output logic                          credit_err
);
  localparam int AW = $clog2(BufferDepth);
  localparam int CW = $clog2(CreditInit+1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(BufferDepth);
  localparam logic [AW:0]   SKID  = (AW+1)'(SkidSlots);
  localparam logic [CW-1:0] CINIT = CW'(CreditInit);

  logic [DataWidth-1:0] mem [BufferDepth];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_nxt;
  logic                 send, push, in_vld, full, ret_ok;
  logic [DataWidth-1:0] head, head_out;
  logic [CW-1:0]        credit_nxt;

  assign in_vld = in_data[DataWidth-1];
  assign full   = (count == DEPTH);
  assign send   = (count != '0) && (credit_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push   = in_vld && (!full || send);
  assign ret_ok = credit_return && (credit_count != CINIT);
  assign head   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, send})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    credit_nxt = credit_count;
    case ({ret_ok, send})
      2'b10:   credit_nxt = credit_count + 1'b1;
      2'b01:   credit_nxt = credit_count - 1'b1;
      default: credit_nxt = credit_count;
    endcase
  end

`ifdef MUX_OUT_PORT_AGING_EN
  localparam int GW = $clog2(AgeThreshold+1);
  localparam logic [GW-1:0] AGE_MAX = GW'(AgeThreshold);
  logic [GW-1:0] age;

  // Age counts cycles the current head sat un-sent; a new head starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             age <= '0;
    else if (send)                       age <= '0;
    else if (count != '0 && age != AGE_MAX) age <= age + 1'b1;
  end

  always_comb begin
    head_out = head;
    if (age == AGE_MAX && head[PriorityPos+:8] != 8'hFF)
      head_out[PriorityPos+:8] = head[PriorityPos+:8] + 8'd1;
  end
`else
  assign head_out = head;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_data     <= '0;
      out_stall    <= 1'b0;
      credit_count <= CINIT;
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      out_data     <= send ? head_out : '0;
      // Stall on post-update free space so the mux's in-flight words still fit.
      out_stall    <= (DEPTH - count_nxt) <= SKID;
      credit_count <= credit_nxt;
      if (in_vld && !push)                           overflow_err <= 1'b1;
      if (credit_return && credit_count == CINIT)    credit_err   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_out_port.sv
// Randomized bench for mux_out_port against a queue-based reference model of the port.
module tb_mux_out_port;
  localparam int DW = 256, PP = 152, DEPTH = 8, SKID = 3, CI = 4, TH = 16;

  logic          clk = 1'b0, rst = 1'b1, credit_return = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic          out_stall, overflow_err, credit_err;
  logic [2:0]    credit_count;

  int n_tests = 0, n_fail = 0;

  mux_out_port #(.DataWidth(DW), .PriorityPos(PP), .BufferDepth(DEPTH), .SkidSlots(SKID),
                 .CreditInit(CI), .AgeThreshold(TH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .credit_return(credit_return),
    .out_data(out_data), .out_stall(out_stall), .credit_count(credit_count),
    .overflow_err(overflow_err), .credit_err(credit_err));

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_out;
  int            m_cred, m_wait;
  logic          m_stall, m_ovf, m_cerr;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_out = '0; m_cred = CI; m_wait = 0; m_stall = 0; m_ovf = 0; m_cerr = 0;
  endtask

  function automatic logic [DW-1:0] aged(input logic [DW-1:0] w, input int waited);
    logic [DW-1:0] r = w;
`ifdef MUX_OUT_PORT_AGING_EN
    if (waited >= TH && w[PP+:8] != 8'hFF) r[PP+:8] = w[PP+:8] + 8'd1;
`endif
    return r;
  endfunction

  task automatic m_step(input logic [DW-1:0] w, input logic cr);
    bit snd = (q.size() > 0) && (m_cred > 0);
    bit cr_ok = cr;
    m_out = '0;
    if (snd) begin
      m_out = aged(q.pop_front(), m_wait);
      m_wait = 0;
    end else if (q.size() > 0) begin
      m_wait = m_wait + 1;
    end
    if (w[DW-1]) begin
      if (q.size() < DEPTH) q.push_back(w);
      else m_ovf = 1;
    end
    if (cr && m_cred == CI) begin
      m_cerr = 1; cr_ok = 0;
    end
    m_cred  = m_cred + int'(cr_ok) - int'(snd);
    m_stall = (DEPTH - q.size()) <= SKID;
  endtask

  task automatic check_all();
    chk("out_data", out_data, m_out);
    chk("out_stall", DW'(out_stall), DW'(m_stall));
    chk("credit_count", DW'(credit_count), DW'(m_cred));
    chk("overflow_err", DW'(overflow_err), DW'(m_ovf));
    chk("credit_err", DW'(credit_err), DW'(m_cerr));
  endtask

  function automatic logic [DW-1:0] rnd_word(input logic [7:0] prio, input bit use_prio);
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32+:32] = $urandom;
    if (use_prio) w[PP+:8] = prio;
    w[DW-1] = 1'b1;
    return w;
  endfunction

  // one clock: drive at negedge, advance model, check at next negedge
  task automatic cyc(input bit v, input logic [DW-1:0] w, input logic cr);
    in_data = v ? w : '0;
    in_data[DW-1] = v;
    credit_return = cr;
    m_step(in_data, cr);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_data = '0; credit_return = 1'b0;
    #1;
    m_reset();
    chk("rst_out_data", out_data, '0);
    chk("rst_credit", DW'(credit_count), DW'(CI));
    chk("rst_stall", DW'(out_stall), '0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // back-to-back 5 words, no credits returned: 4 sent, 5th held
    for (int i = 0; i < 5; i++) cyc(1, rnd_word(8'h0, 0), 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0);
    chk("drain_credit0", DW'(credit_count), '0);
    chk("drain_out_idle", out_data, '0);

    // one returned credit releases exactly one word
    cyc(1, rnd_word(8'h0, 0), 1);
    cyc(0, '0, 0);
    chk("one_credit_sent", DW'(out_data[DW-1]), DW'(1'b1));
    cyc(0, '0, 0);
    chk("one_credit_back0", DW'(credit_count), '0);

    // fill beyond capacity with credits withheld
    for (int i = 0; i < 9; i++) cyc(1, rnd_word(8'h0, 0), 0);
    chk("fill_stall", DW'(out_stall), DW'(1'b1));
    chk("fill_ovf", DW'(overflow_err), DW'(1'b1));

    // reset with words queued
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, '0, 0);
    chk("post_rst_idle", out_data, '0);

    // same-cycle return and send at 2 credits, then surplus return
    cyc(1, rnd_word(8'h0, 0), 0);
    cyc(1, rnd_word(8'h0, 0), 0);
    cyc(0, '0, 0);
    cyc(1, rnd_word(8'h0, 0), 0);
    cyc(0, '0, 1);
    chk("same_cycle_cred2", DW'(credit_count), DW'(2));
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    chk("surplus_cerr", DW'(credit_err), DW'(1'b1));

`ifdef MUX_OUT_PORT_AGING_EN
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, rnd_word(8'h0, 0), 0);
    cyc(1, rnd_word(8'h10, 1), 0);
    cyc(1, rnd_word(8'hFF, 1), 0);
    for (int i = 0; i < TH + 2; i++) cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("aged_prio10", DW'(out_data[PP+:8]), DW'(8'h11));
    for (int i = 0; i < TH + 2; i++) cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("aged_prioFF", DW'(out_data[PP+:8]), DW'(8'hFF));
`endif

    // randomized traffic with a well-behaved downstream receiver
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int vp = (i / 250) % 2 ? 90 : 40;
      int cp = (i / 100) % 3 == 0 ? 5 : 60;
      bit v  = $urandom_range(99) < vp;
      bit cr = (m_cred < CI) && ($urandom_range(99) < cp);
      logic [7:0] pr = $urandom_range(1) ? 8'hFF : 8'($urandom);
      if (i == 1200) do_reset();
      cyc(v, rnd_word(pr, 1), cr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
